// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Round-robin on ties, registered handshakes, watchdog turns a hung access into bus_err.
module mem_bus_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [BIT_WIDTH-1:0] i_addr,
    output logic [BIT_WIDTH-1:0] i_rdata,
    output logic                 i_ack_n,
    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [1:0]           d_size,
    input  logic [BIT_WIDTH-1:0] d_addr,
    input  logic [BIT_WIDTH-1:0] d_wdata,
    output logic [BIT_WIDTH-1:0] d_rdata,
    output logic                 d_ack_n,
    output logic                 m_req,
    output logic                 m_write,
    output logic [1:0]           m_size,
    output logic [BIT_WIDTH-1:0] m_addr,
    output logic [BIT_WIDTH-1:0] m_wdata,
    input  logic [BIT_WIDTH-1:0] m_rdata,
    input  logic                 m_ack_n,
    output logic                 bus_err,
    output logic [1:0]           o_dbg_state
);

    // Handshake: a requester raises req and holds it (with stable address/data)
    // until it sees its ack_n low for one cycle; memory likewise sees m_req held
    // until it answers with m_ack_n low, which is honoured only while busy.

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_d;
    logic [CW-1:0]          r_cnt;
    logic                   r_m_req;
    logic                   r_m_write;
    logic [1:0]             r_m_size;
    logic [BIT_WIDTH-1:0]   r_m_addr;
    logic [BIT_WIDTH-1:0]   r_m_wdata;
    logic [BIT_WIDTH-1:0]   r_i_rdata;
    logic [BIT_WIDTH-1:0]   r_d_rdata;
    logic                   r_i_ack_n;
    logic                   r_d_ack_n;
    logic                   r_bus_err;

    logic                   w_grant_i;
    logic                   w_grant_d;
    logic                   w_mem_ack;
    logic                   w_timeout;
    logic                   w_done;
    logic [BIT_WIDTH-1:0]   w_resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_mem_ack    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (i_req && d_req) begin
                    w_grant_d = !r_last_d;
                    w_grant_i = r_last_d;
                end else begin
                    w_grant_d = d_req;
                    w_grant_i = i_req;
                end
                if (w_grant_d) begin
                    w_next_state = ST_DBUSY;
                end else if (w_grant_i) begin
                    w_next_state = ST_IBUSY;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                w_mem_ack = !m_ack_n;
                w_timeout = m_ack_n && (r_cnt >= CNT_LAST);
                if (w_mem_ack || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_done      = w_mem_ack || w_timeout;
    assign w_resp_data = w_timeout ? {BIT_WIDTH{1'b1}} : m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_write <= 1'b0;
            r_m_size  <= 2'b00;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack_n <= 1'b1;
            r_d_ack_n <= 1'b1;
            r_bus_err <= 1'b0;
        end else begin
            r_i_ack_n <= 1'b1;
            r_d_ack_n <= 1'b1;
            r_bus_err <= 1'b0;

            if (w_grant_i) begin
                r_m_req   <= 1'b1;
                r_m_addr  <= i_addr;
                r_m_write <= 1'b0;
                r_m_size  <= 2'b00;
                r_last_d  <= 1'b0;
                r_cnt     <= '0;
            end else if (w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_addr  <= d_addr;
                r_m_write <= d_write;
                r_m_size  <= d_size;
                r_m_wdata <= d_wdata;
                r_last_d  <= 1'b1;
                r_cnt     <= '0;
            end

            if (w_done) begin
                r_m_req   <= 1'b0;
                r_bus_err <= w_timeout;
                if (r_state == ST_IBUSY) begin
                    r_i_ack_n <= 1'b0;
                    r_i_rdata <= w_resp_data;
                end else begin
                    r_d_ack_n <= 1'b0;
                    // A store returns nothing, so the last load value is kept.
                    if (!r_m_write) begin
                        r_d_rdata <= w_resp_data;
                    end
                end
            end else if ((r_state == ST_IBUSY) || (r_state == ST_DBUSY)) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign i_rdata     = r_i_rdata;
    assign i_ack_n     = r_i_ack_n;
    assign d_rdata     = r_d_rdata;
    assign d_ack_n     = r_d_ack_n;
    assign m_req       = r_m_req;
    assign m_write     = r_m_write;
    assign m_size      = r_m_size;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one DUT with the default watchdog and one with a
// four-cycle watchdog, each checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [31:0] i_rdata;
    logic        i_ack_n;
    logic [31:0] d_rdata;
    logic        d_ack_n;
    logic        m_req;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        bus_err;
  } out_t;

  typedef struct packed {
    logic own_d;
    logic last_d;
    int   waited;
    out_t o;
  } mdl_t;

  typedef struct packed {
    int          lat;
    int          mreq_n;
    int          addr_chg;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        berr;
    logic        other_ack;
    logic        done;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance A (TIMEOUT 255) ----------------
  logic        i_req_a, d_req_a, d_write_a, m_ack_n_a;
  logic [31:0] i_addr_a, d_addr_a, d_wdata_a, m_rdata_a;
  logic [1:0]  d_size_a;
  logic [31:0] i_rdata_a, d_rdata_a, m_addr_a, m_wdata_a;
  logic        i_ack_n_a, d_ack_n_a, m_req_a, m_write_a, bus_err_a;
  logic [1:0]  m_size_a, dbg_a;

  mem_bus_arbiter #(.BIT_WIDTH(32), .TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_req(i_req_a), .i_addr(i_addr_a), .i_rdata(i_rdata_a), .i_ack_n(i_ack_n_a),
    .d_req(d_req_a), .d_write(d_write_a), .d_size(d_size_a), .d_addr(d_addr_a),
    .d_wdata(d_wdata_a), .d_rdata(d_rdata_a), .d_ack_n(d_ack_n_a),
    .m_req(m_req_a), .m_write(m_write_a), .m_size(m_size_a), .m_addr(m_addr_a),
    .m_wdata(m_wdata_a), .m_rdata(m_rdata_a), .m_ack_n(m_ack_n_a),
    .bus_err(bus_err_a), .o_dbg_state(dbg_a)
  );

  // ---------------- instance B (TIMEOUT 4) ----------------
  logic        i_req_b, d_req_b, d_write_b, m_ack_n_b;
  logic [31:0] i_addr_b, d_addr_b, d_wdata_b, m_rdata_b;
  logic [1:0]  d_size_b;
  logic [31:0] i_rdata_b, d_rdata_b, m_addr_b, m_wdata_b;
  logic        i_ack_n_b, d_ack_n_b, m_req_b, m_write_b, bus_err_b;
  logic [1:0]  m_size_b, dbg_b;

  mem_bus_arbiter #(.BIT_WIDTH(32), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req(i_req_b), .i_addr(i_addr_b), .i_rdata(i_rdata_b), .i_ack_n(i_ack_n_b),
    .d_req(d_req_b), .d_write(d_write_b), .d_size(d_size_b), .d_addr(d_addr_b),
    .d_wdata(d_wdata_b), .d_rdata(d_rdata_b), .d_ack_n(d_ack_n_b),
    .m_req(m_req_b), .m_write(m_write_b), .m_size(m_size_b), .m_addr(m_addr_b),
    .m_wdata(m_wdata_b), .m_rdata(m_rdata_b), .m_ack_n(m_ack_n_b),
    .bus_err(bus_err_b), .o_dbg_state(dbg_b)
  );

  out_t out_a, out_b;
  assign out_a = {i_rdata_a, i_ack_n_a, d_rdata_a, d_ack_n_a, m_req_a, m_write_a,
                  m_size_a, m_addr_a, m_wdata_a, bus_err_a};
  assign out_b = {i_rdata_b, i_ack_n_b, d_rdata_b, d_ack_n_b, m_req_b, m_write_b,
                  m_size_b, m_addr_b, m_wdata_b, bus_err_b};

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  logic grant_q[$];
  int   both_low;

  // ---------------- memory responders ----------------
  // The memory answers on the mem_lat-th cycle m_req is seen high (0 = never);
  // stray makes it pulse ack while not requested.
  int          mem_lat_a = 1, busy_n_a = 0, mem_lat_b = 1, busy_n_b = 0;
  logic [31:0] mem_data_a = '0, mem_data_b = '0;
  bit          stray_a = 1'b0;

  always @(negedge clk) begin
    if (m_req_a === 1'b1) begin
      busy_n_a = busy_n_a + 1;
      m_ack_n_a = !(mem_lat_a != 0 && busy_n_a == mem_lat_a);
    end else begin
      busy_n_a = 0;
      m_ack_n_a = !stray_a;
    end
    m_rdata_a = mem_data_a;
  end

  always @(negedge clk) begin
    if (m_req_b === 1'b1) begin
      busy_n_b = busy_n_b + 1;
      m_ack_n_b = !(mem_lat_b != 0 && busy_n_b == mem_lat_b);
    end else begin
      busy_n_b = 0;
      m_ack_n_b = 1'b1;
    end
    m_rdata_b = mem_data_b;
  end

  // ---------------- behavioural model ----------------
  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.o.i_ack_n = 1'b1;
    m.o.d_ack_n = 1'b1;
    return m;
  endfunction

  // Phase is read from the model's own outputs: m_req high = waiting on memory,
  // an ack_n low = response cycle, otherwise idle and free to grant.
  function automatic mdl_t mdl_step(mdl_t m, logic rst_v, logic ireq, logic [31:0] iaddr,
                                    logic dreq, logic dwr, logic [1:0] dsz, logic [31:0] daddr,
                                    logic [31:0] dwd, logic [31:0] mrd, logic mack_n, int tmo);
    mdl_t        n;
    logic [31:0] data;
    logic        pick_d;
    if (rst_v) return mdl_reset();
    n = m;
    n.o.i_ack_n = 1'b1;
    n.o.d_ack_n = 1'b1;
    n.o.bus_err = 1'b0;
    if (m.o.m_req) begin
      if (!mack_n || (m.waited + 1 >= tmo)) begin
        data = mack_n ? 32'hFFFF_FFFF : mrd;
        n.o.m_req   = 1'b0;
        n.o.bus_err = mack_n;
        if (m.own_d) begin
          n.o.d_ack_n = 1'b0;
          if (!m.o.m_write) n.o.d_rdata = data;
        end else begin
          n.o.i_ack_n = 1'b0;
          n.o.i_rdata = data;
        end
      end else begin
        n.waited = m.waited + 1;
      end
    end else if (m.o.i_ack_n && m.o.d_ack_n && (ireq || dreq)) begin
      pick_d   = dreq && !(ireq && m.last_d);
      n.own_d  = pick_d;
      n.last_d = pick_d;
      n.waited = 0;
      n.o.m_req = 1'b1;
      if (pick_d) begin
        n.o.m_addr  = daddr;
        n.o.m_write = dwr;
        n.o.m_size  = dsz;
        n.o.m_wdata = dwd;
      end else begin
        n.o.m_addr  = iaddr;
        n.o.m_write = 1'b0;
        n.o.m_size  = 2'b00;
      end
    end
    return n;
  endfunction

  mdl_t mdl_a, mdl_b;

  always @(posedge clk) begin
    mdl_a <= mdl_step(mdl_a, rst, i_req_a, i_addr_a, d_req_a, d_write_a, d_size_a, d_addr_a,
                      d_wdata_a, m_rdata_a, m_ack_n_a, 255);
    mdl_b <= mdl_step(mdl_b, rst, i_req_b, i_addr_b, d_req_b, d_write_b, d_size_b, d_addr_b,
                      d_wdata_b, m_rdata_b, m_ack_n_b, 4);
  end

  // ---------------- scoreboard ----------------
  task automatic cmp_out(input string tag, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got {irdata=%h iack_n=%b drdata=%h dack_n=%b mreq=%b mwr=%b msz=%b maddr=%h mwd=%h berr=%b} required {irdata=%h iack_n=%b drdata=%h dack_n=%b mreq=%b mwr=%b msz=%b maddr=%h mwd=%h berr=%b}",
               tag, $time, act.i_rdata, act.i_ack_n, act.d_rdata, act.d_ack_n, act.m_req,
               act.m_write, act.m_size, act.m_addr, act.m_wdata, act.bus_err,
               exp.i_rdata, exp.i_ack_n, exp.d_rdata, exp.d_ack_n, exp.m_req,
               exp.m_write, exp.m_size, exp.m_addr, exp.m_wdata, exp.bus_err);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_out("cycle_a", out_a, mdl_a.o);
      cmp_out("cycle_b", out_b, mdl_b.o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit inst, input bit use_d, input bit req, input bit wr,
                       input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    if (!inst) begin
      if (use_d) begin
        d_req_a = req; d_write_a = wr; d_size_a = sz; d_addr_a = addr; d_wdata_a = wd;
      end else begin
        i_req_a = req; i_addr_a = addr;
      end
    end else begin
      if (use_d) begin
        d_req_b = req; d_write_b = wr; d_size_b = sz; d_addr_b = addr; d_wdata_b = wd;
      end else begin
        i_req_b = req; i_addr_b = addr;
      end
    end
  endtask

  task automatic txn(input bit inst, input bit use_d, input bit wr, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd, output res_t r);
    logic        ack, oth, mreq;
    logic [31:0] maddr;
    r = '0;
    @(negedge clk);
    drive(inst, use_d, 1'b1, wr, sz, addr, wd);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      mreq  = inst ? m_req_b : m_req_a;
      maddr = inst ? m_addr_b : m_addr_a;
      if (mreq) begin
        if (r.mreq_n == 0) begin
          r.addr = maddr;
          r.wr   = inst ? m_write_b : m_write_a;
          r.sz   = inst ? m_size_b : m_size_a;
          r.wd   = inst ? m_wdata_b : m_wdata_a;
        end else if (maddr !== r.addr) begin
          r.addr_chg = r.addr_chg + 1;
        end
        r.mreq_n = r.mreq_n + 1;
      end
      ack = use_d ? (inst ? d_ack_n_b : d_ack_n_a) : (inst ? i_ack_n_b : i_ack_n_a);
      oth = use_d ? (inst ? i_ack_n_b : i_ack_n_a) : (inst ? d_ack_n_b : d_ack_n_a);
      if (!oth) r.other_ack = 1'b1;
      if (!ack) begin
        r.lat   = c;
        r.rdata = use_d ? (inst ? d_rdata_b : d_rdata_a) : (inst ? i_rdata_b : i_rdata_a);
        r.berr  = inst ? bus_err_b : bus_err_a;
        r.done  = 1'b1;
        break;
      end
    end
    drive(inst, use_d, 1'b0, wr, sz, addr, wd);
    if (!r.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_wait: got no ack within 400 cycles required an ack (inst=%0d d=%0d)",
               inst, use_d);
    end
  endtask

  // Both requesters held high on A; records which side each ack_n pulse belongs to.
  task automatic tie_run(input int n_want);
    grant_q.delete();
    both_low = 0;
    @(negedge clk);
    i_req_a = 1'b1; i_addr_a = 32'h0000_0040;
    d_req_a = 1'b1; d_write_a = 1'b0; d_size_a = 2'b01; d_addr_a = 32'h0000_0080;
    d_wdata_a = 32'h0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!i_ack_n_a && !d_ack_n_a) both_low++;
      if (!d_ack_n_a) grant_q.push_back(1'b1);
      else if (!i_ack_n_a) grant_q.push_back(1'b0);
      if (grant_q.size() >= n_want) break;
    end
    i_req_a = 1'b0;
    d_req_a = 1'b0;
    chk("tie_ack_count", grant_q.size(), n_want);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  res_t r;

  initial begin
    rst = 1'b1;
    i_req_a = 0; i_addr_a = 0; d_req_a = 0; d_write_a = 0; d_size_a = 0; d_addr_a = 0;
    d_wdata_a = 0;
    i_req_b = 0; i_addr_b = 0; d_req_b = 0; d_write_b = 0; d_size_b = 0; d_addr_b = 0;
    d_wdata_b = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_m_req", m_req_a, 0);
    chk("rst_m_addr", m_addr_a, 0);
    chk("rst_m_wdata", m_wdata_a, 0);
    chk("rst_i_ack_n", i_ack_n_a, 1);
    chk("rst_d_ack_n", d_ack_n_a, 1);
    chk("rst_i_rdata", i_rdata_a, 0);
    chk("rst_bus_err", bus_err_a, 0);
    rst = 1'b0;

    // memory ack while idle must be ignored
    stray_a = 1'b1; mem_data_a = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    stray_a = 1'b0;
    chk("stray_ack_no_req", m_req_a, 0);
    chk("stray_ack_no_iack", i_ack_n_a, 1);
    chk("stray_ack_rdata", i_rdata_a, 0);

    // single fetch, memory answers after one cycle
    mem_lat_a = 1; mem_data_a = 32'h0010_0093;
    txn(1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, r);
    chk("fetch_latency", r.lat, 2);
    chk("fetch_mreq_cycles", r.mreq_n, 1);
    chk("fetch_m_addr", r.addr, 32'h0000_0010);
    chk("fetch_m_write", r.wr, 0);
    chk("fetch_m_size", r.sz, 0);
    chk("fetch_m_wdata", r.wd, 0);
    chk("fetch_rdata", r.rdata, 32'h0010_0093);
    chk("fetch_no_d_ack", r.other_ack, 0);

    // byte store: d_rdata must keep its reset value
    mem_lat_a = 1; mem_data_a = 32'hDEAD_BEEF;
    txn(1'b0, 1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041, r);
    chk("store_latency", r.lat, 2);
    chk("store_m_write", r.wr, 1);
    chk("store_m_size", r.sz, 2'b10);
    chk("store_m_addr", r.addr, 32'hF000_0000);
    chk("store_m_wdata", r.wd, 32'h0000_0041);
    chk("store_d_rdata_kept", r.rdata, 0);

    // five-cycle memory latency on a load
    mem_lat_a = 5; mem_data_a = 32'h1234_5678;
    txn(1'b0, 1'b1, 1'b0, 2'b00, 32'h0800_0004, 32'hAAAA_5555, r);
    chk("slow_mreq_cycles", r.mreq_n, 5);
    chk("slow_latency", r.lat, 6);
    chk("slow_addr_stable", r.addr_chg, 0);
    chk("slow_rdata", r.rdata, 32'h1234_5678);

    // last grant was D, so the next tie goes to I
    mem_lat_a = 1; mem_data_a = 32'h0000_0013;
    tie_run(1);
    chk("tie_after_d_first", grant_q.size() > 0 ? grant_q[0] : 1'bx, 1'b0);

    // fresh reset: three held ties go D, I, D
    do_reset();
    mem_lat_a = 2; mem_data_a = 32'h1111_2222;
    tie_run(3);
    chk("tie_grant0", grant_q.size() > 0 ? grant_q[0] : 1'bx, 1'b1);
    chk("tie_grant1", grant_q.size() > 1 ? grant_q[1] : 1'bx, 1'b0);
    chk("tie_grant2", grant_q.size() > 2 ? grant_q[2] : 1'bx, 1'b1);
    chk("tie_no_overlap", both_low, 0);

    // reset while a load is stuck in the busy state
    @(negedge clk);
    mem_lat_a = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'h0000_0077);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", m_req_a, 1);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'h0000_0077);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_m_req", m_req_a, 0);
    chk("midrst_m_addr", m_addr_a, 0);
    chk("midrst_m_wdata", m_wdata_a, 0);
    chk("midrst_d_ack_n", d_ack_n_a, 1);
    chk("midrst_i_rdata", i_rdata_a, 0);
    chk("midrst_d_rdata", d_rdata_a, 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_late_ack", d_ack_n_a, 1);
    mem_lat_a = 1; mem_data_a = 32'h0000_5555;
    tie_run(1);
    chk("midrst_tie_to_d", grant_q.size() > 0 ? grant_q[0] : 1'bx, 1'b1);

    // watchdog on B: memory never answers
    mem_lat_b = 0;
    txn(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h0, r);
    chk("wdog_mreq_cycles", r.mreq_n, 4);
    chk("wdog_latency", r.lat, 5);
    chk("wdog_bus_err", r.berr, 1);
    chk("wdog_d_rdata", r.rdata, 32'hFFFF_FFFF);
    chk("wdog_no_i_ack", r.other_ack, 0);
    @(negedge clk);
    chk("wdog_bus_err_pulse", bus_err_b, 0);

    // ack on the very last busy cycle beats the watchdog
    mem_lat_b = 4; mem_data_b = 32'h0000_ABCD;
    txn(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0104, 32'h0, r);
    chk("wdog_edge_latency", r.lat, 5);
    chk("wdog_edge_bus_err", r.berr, 0);
    chk("wdog_edge_rdata", r.rdata, 32'h0000_ABCD);

    // fetch after the timeout recovers normally
    mem_lat_b = 2; mem_data_b = 32'h0000_0013;
    txn(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0200, 32'h0, r);
    chk("post_wdog_latency", r.lat, 3);
    chk("post_wdog_rdata", r.rdata, 32'h0000_0013);
    chk("post_wdog_bus_err", r.berr, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of stimulus required finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
